// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - parallel-to-serial transmitter with one-word holding buffer and underflow flag
module ser_tx #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_VAL  = 1'b0
) (
    input  logic             CP,
    input  logic             RN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic             STREAM,
    input  logic             CLR_UF,
    output logic             Q,
    output logic             Q_VALID,
    output logic             SOF,
    output logic             UNDERFLOW
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             full_q, full_d;
    logic             q_q, q_d;
    logic             qv_q, qv_d;
    logic             sof_q, sof_d;
    logic             uf_q, uf_d;

    logic             xfer;
    logic             load_pt;
    logic             have_src;
    logic             bypass;
    logic             uf_set;
    logic [WIDTH-1:0] src;

    // The shifter always keeps the next bit to send at its head position.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign DIN_READY = RN & ~full_q;
    assign xfer      = DIN_VALID & DIN_READY;
    assign load_pt   = (state_q == ST_IDLE) || (cnt_q == LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        buf_d    = buf_q;
        full_d   = full_q;
        q_d      = q_q;
        qv_d     = qv_q;
        sof_d    = sof_q;
        src      = '0;
        have_src = 1'b0;
        bypass   = 1'b0;
        uf_set   = 1'b0;

        if (load_pt) begin
            if (full_q) begin
                src      = buf_q;
                have_src = 1'b1;
                full_d   = 1'b0;
            end else if (xfer) begin
                src      = DIN;
                have_src = 1'b1;
                bypass   = 1'b1;
            end
        end

        if (xfer && !bypass) begin
            buf_d  = DIN;
            full_d = 1'b1;
        end

        if (load_pt) begin
            cnt_d = '0;
            if (have_src) begin
                state_d = ST_SHIFT;
                q_d     = head_bit(src);
                shift_d = advance(src);
                qv_d    = 1'b1;
                sof_d   = 1'b1;
            end else begin
                state_d = ST_IDLE;
                q_d     = IDLE_VAL;
                qv_d    = 1'b0;
                sof_d   = 1'b0;
                uf_set  = (state_q == ST_SHIFT) && STREAM;
            end
        end else begin
            cnt_d   = cnt_q + 1'b1;
            q_d     = head_bit(shift_q);
            shift_d = advance(shift_q);
            qv_d    = 1'b1;
            sof_d   = 1'b0;
        end

        // A new underflow takes priority over a coincident clear.
        uf_d = uf_set | (uf_q & ~CLR_UF);
    end

    always_ff @(posedge CP) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            q_q     <= IDLE_VAL;
            qv_q    <= 1'b0;
            sof_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            sof_q   <= sof_d;
            uf_q    <= uf_d;
        end
    end

    assign Q         = q_q;
    assign Q_VALID   = qv_q;
    assign SOF       = sof_q;
    assign UNDERFLOW = uf_q;

endmodule

// File: tb/tb_ser_tx.sv
// tb/tb_ser_tx.sv - self-checking bench for ser_tx against a word/bit-queue reference model
module tb_ser_tx;

    logic       clk;
    logic       rn;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       stream;
    logic       clr_uf;
    logic       q;
    logic       q_valid;
    logic       sof;
    logic       uf;

    logic [7:0] l_din;
    logic       l_valid;
    logic       l_ready;
    logic       l_q;
    logic       l_qv;
    logic       l_sof;
    logic       l_uf;

    int tests;
    int fails;

    // Reference model: words waiting to start, and bits of the current word still to appear.
    bit [7:0] m_wait[$];
    bit       m_bits[$];
    bit       m_q, m_v, m_sof, m_uf;

    ser_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_dut (
        .CP(clk), .RN(rn), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
        .STREAM(stream), .CLR_UF(clr_uf), .Q(q), .Q_VALID(q_valid), .SOF(sof), .UNDERFLOW(uf)
    );

    ser_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_lsb (
        .CP(clk), .RN(rn), .DIN(l_din), .DIN_VALID(l_valid), .DIN_READY(l_ready),
        .STREAM(1'b0), .CLR_UF(1'b0), .Q(l_q), .Q_VALID(l_qv), .SOF(l_sof), .UNDERFLOW(l_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_ready();
        return rn && (m_wait.size() == 0);
    endfunction

    task automatic model_start(input bit [7:0] w);
        for (int i = 7; i >= 0; i--) m_bits.push_back(w[i]);
        m_q   = m_bits.pop_front();
        m_v   = 1'b1;
        m_sof = 1'b1;
    endtask

    task automatic model_edge();
        bit t;
        bit set;
        if (!rn) begin
            m_wait.delete();
            m_bits.delete();
            m_q = 0; m_v = 0; m_sof = 0; m_uf = 0;
            return;
        end
        t   = din_valid && (m_wait.size() == 0);
        set = 1'b0;
        if (m_bits.size() == 0) begin
            if (m_wait.size() > 0) begin
                model_start(m_wait.pop_front());
                if (t) m_wait.push_back(din);
            end else if (t) begin
                model_start(din);
            end else begin
                if (m_v && stream) set = 1'b1;
                m_q = 0; m_v = 0; m_sof = 0;
            end
        end else begin
            m_q   = m_bits.pop_front();
            m_v   = 1'b1;
            m_sof = 1'b0;
            if (t) m_wait.push_back(din);
        end
        m_uf = set | (m_uf & !clr_uf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rn = 0; din = 0; din_valid = 0; stream = 0; clr_uf = 0; l_din = 0; l_valid = 0;
        tick(); tick();
        tests++;
        if ({q, q_valid, sof, uf} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs: got %b expected 0000", {q, q_valid, sof, uf});
        end
        tests++;
        if (din_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready_low: got %b expected 0", din_ready);
        end
        rn = 1; #1;
        tests++;
        if (din_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready_release: got %b expected 1", din_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        din = w; din_valid = 1; stream = 0;
        tick();
        din_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({q, q_valid, sof} !== {w[7-i], 1'b1, i == 0}) begin
                fails++;
                $display("FAIL single_bit%0d: got q/v/sof=%b expected %b", i, {q, q_valid, sof},
                         {w[7-i], 1'b1, i == 0});
            end
            tick();
        end
        tests++;
        if ({q, q_valid, sof} !== 3'b000) begin
            fails++; $display("FAIL single_idle: got %b expected 000", {q, q_valid, sof});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        w = 16'hF00F;
        for (int j = 0; j < 16; j++) begin
            din_valid = (j < 2);
            din       = (j == 0) ? 8'hF0 : 8'h0F;
            tick();
            tests++;
            if ({q, q_valid, sof, din_ready} !==
                {w[15-j], 1'b1, (j == 0 || j == 8), !(j >= 1 && j <= 7)}) begin
                fails++;
                $display("FAIL b2b_bit%0d: got q/v/sof/rdy=%b expected %b", j,
                         {q, q_valid, sof, din_ready},
                         {w[15-j], 1'b1, (j == 0 || j == 8), !(j >= 1 && j <= 7)});
            end
        end
        din_valid = 0;
        tick();
        tests++;
        if (q_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_idle: got %b expected 0", q_valid);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] w;
        w = 16'h813C;
        stream = 1; clr_uf = 0;
        for (int j = 0; j < 16; j++) begin
            din_valid = (j == 0 || j == 8);
            din       = (j == 0) ? 8'h81 : 8'h3C;
            if (j == 15) stream = 0;
            tests++;
            if (din_ready !== 1'b1) begin
                fails++; $display("FAIL bypass_ready%0d: got %b expected 1", j, din_ready);
            end
            tick();
            tests++;
            if ({q, q_valid, sof, uf} !== {w[15-j], 1'b1, (j == 0 || j == 8), 1'b0}) begin
                fails++;
                $display("FAIL bypass_bit%0d: got q/v/sof/uf=%b expected %b", j,
                         {q, q_valid, sof, uf}, {w[15-j], 1'b1, (j == 0 || j == 8), 1'b0});
            end
        end
        din_valid = 0;
        tick();
        tests++;
        if ({q_valid, uf} !== 2'b00) begin
            fails++; $display("FAIL bypass_end: got v/uf=%b expected 00", {q_valid, uf});
        end
    endtask

    task automatic test_underflow();
        stream = 1; clr_uf = 0; din = 8'h55; din_valid = 1;
        tick();
        din_valid = 0;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (uf !== 1'b0) begin
            fails++; $display("FAIL uf_early: got %b expected 0", uf);
        end
        tick();
        tests++;
        if ({uf, q_valid} !== 2'b10) begin
            fails++; $display("FAIL uf_set: got uf/v=%b expected 10", {uf, q_valid});
        end
        tick();
        tests++;
        if (uf !== 1'b1) begin
            fails++; $display("FAIL uf_sticky_idle: got %b expected 1", uf);
        end
        din = 8'h55; din_valid = 1;
        tick();
        din_valid = 0;
        for (int i = 0; i < 7; i++) tick();
        clr_uf = 1;
        tick();
        tests++;
        if (uf !== 1'b1) begin
            fails++; $display("FAIL uf_set_wins: got %b expected 1", uf);
        end
        tick();
        tests++;
        if (uf !== 1'b0) begin
            fails++; $display("FAIL uf_clear: got %b expected 0", uf);
        end
        clr_uf = 0; stream = 0;
    endtask

    task automatic test_mid_reset();
        din = 8'hC3; din_valid = 1;
        tick();
        din = 8'h5A;
        tick();
        din_valid = 0;
        tick();
        rn = 0;
        tick();
        tests++;
        if ({q, q_valid, sof, uf, din_ready} !== 5'b00000) begin
            fails++;
            $display("FAIL midrst_outputs: got %b expected 00000", {q, q_valid, sof, uf, din_ready});
        end
        rn = 1;
        tick();
        tests++;
        if (din_ready !== 1'b1) begin
            fails++; $display("FAIL midrst_ready: got %b expected 1", din_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (q_valid !== 1'b0) begin
                fails++; $display("FAIL midrst_no_buffered_word%0d: got %b expected 0", i, q_valid);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        l_din = w; l_valid = 1;
        tick();
        l_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({l_q, l_qv, l_sof} !== {w[i], 1'b1, i == 0}) begin
                fails++;
                $display("FAIL lsb_bit%0d: got %b expected %b", i, {l_q, l_qv, l_sof}, {w[i], 1'b1, i == 0});
            end
            tick();
        end
        tests++;
        if (l_qv !== 1'b0) begin
            fails++; $display("FAIL lsb_idle: got %b expected 0", l_qv);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) stream = ~stream;
            clr_uf    = ($urandom_range(0, 15) == 0);
            rn        = ($urandom_range(0, 99) != 0);
            #1;
            tests++;
            if (din_ready !== model_ready()) begin
                fails++; $display("FAIL rand_ready@%0d: got %b expected %b", c, din_ready, model_ready());
            end
            tick();
            tests++;
            if ({q, q_valid, sof, uf} !== {m_q, m_v, m_sof, m_uf}) begin
                fails++;
                $display("FAIL rand_out@%0d: got q/v/sof/uf=%b expected %b", c,
                         {q, q_valid, sof, uf}, {m_q, m_v, m_sof, m_uf});
            end
        end
        rn = 1; din_valid = 0; clr_uf = 0; stream = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_q = 0; m_v = 0; m_sof = 0; m_uf = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_underflow();
        test_mid_reset();
        test_lsb_first();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the parallel word width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 The block SHALL have parameter IDLE_VAL, default 0, giving the Q level driven when no word is being sent.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset; the ports are named CP and RN.
REQ-005 CP  input  1  clock; all state changes on the rising edge.
REQ-006 RN  input  1  synchronous active-low reset, sampled on the rising CP edge.
REQ-007 DIN  input  WIDTH  parallel word to transmit.
REQ-008 DIN_VALID  input  1  DIN holds a word to send.
REQ-009 DIN_READY  output  1  block can accept a word this cycle.
REQ-010 STREAM  input  1  continuous stream expected; gaps count as underflow.
REQ-011 CLR_UF  input  1  clears UNDERFLOW.
REQ-012 Q  output  1  registered serial data bit.
REQ-013 Q_VALID  output  1  Q carries a data bit this cycle.
REQ-014 SOF  output  1  Q carries the first bit of a word.
REQ-015 UNDERFLOW  output  1  sticky gap-in-stream flag.

Function
REQ-016 The block SHALL contain a WIDTH-bit shift register, a bit counter (0..WIDTH-1), a one-word holding buffer with a full flag, and a two-state FSM: IDLE and SHIFT.
REQ-017 A transfer SHALL occur on a rising CP edge with DIN_VALID=1 and DIN_READY=1; DIN_READY SHALL equal NOT buffer_full and SHALL be 0 while RN=0.
REQ-018 A load point is any edge in IDLE, or any edge in SHIFT with bit counter = WIDTH-1.
REQ-019 At a load point, the shifter source SHALL be the holding buffer if full (buffer then empties), else DIN if a transfer occurs that edge (bypass), else none.
REQ-020 A transfer not consumed by bypass SHALL write DIN into the holding buffer.
REQ-021 On a load, the FSM SHALL enter or stay in SHIFT, the counter SHALL become 0, and Q, Q_VALID=1 and SOF=1 SHALL present the first bit after that same edge.
REQ-022 In SHIFT with counter < WIDTH-1, each edge SHALL advance the counter by 1 and present the next bit in MSB_FIRST order, with SOF=0 and Q_VALID=1.
REQ-023 At a load point with no source, the FSM SHALL go to or stay in IDLE, and Q=IDLE_VAL, Q_VALID=0 and SOF=0 SHALL hold from that edge.
REQ-024 Latency: a word transferred at edge k into an empty pipeline SHALL have its first bit on Q after edge k; the last bit SHALL appear after edge k+WIDTH-1.
REQ-025 Back-to-back words SHALL be sent with no idle cycle when each next word is transferred no later than the last-bit edge of the current word.
REQ-026 UNDERFLOW SHALL set at a SHIFT-state load point with no source while STREAM=1; it SHALL remain set until an edge with CLR_UF=1.
REQ-027 If set and clear coincide on one edge, set SHALL win.
REQ-028 An edge in IDLE SHALL never set UNDERFLOW.
REQ-029 DIN SHALL be ignored when no transfer occurs; DIN_VALID SHALL have no effect while DIN_READY=0.

Reset
REQ-030 At any edge with RN=0, the block SHALL discard the shifter and buffer contents, clear buffer_full, and set FSM=IDLE, counter=0, Q=IDLE_VAL, Q_VALID=0, SOF=0 and UNDERFLOW=0, regardless of an in-progress word.
REQ-031 At the first edge with RN=1, the block SHALL behave as IDLE with an empty buffer, and a transfer SHALL be accepted at that edge.

Verification (WIDTH=8, MSB_FIRST=1, IDLE_VAL=0)
REQ-032 Single word: 8'hA5 transferred at edge k -> Q = 1,0,1,0,0,1,0,1 after edges k..k+7; SOF=1 only after k; Q_VALID=0 and Q=0 from k+8.
REQ-033 Back-to-back: 8'hF0 at k, 8'h0F at k+1 (buffered), DIN_READY=0 after k+1 until k+8 -> 16 contiguous bits F0 then 0F; SOF after k and k+8; no Q_VALID gap.
REQ-034 Bypass: 8'h81 sent, next word 8'h3C presented only at the last-bit edge -> bypass load, no gap; with STREAM=1, UNDERFLOW stays 0.
REQ-035 Underflow: STREAM=1, single word 8'h55 -> UNDERFLOW=1 after edge k+8; CLR_UF=1 at a later edge -> 0; CLR_UF coincident with a new set -> stays 1.
REQ-036 Mid-word reset: RN=0 at edge k+3 of 8'hC3 with a buffered word -> all outputs at reset values after k+3, buffered word never sent, DIN_READY=1 after first RN=1 edge.
REQ-037 LSB-first: MSB_FIRST=0, 8'h01 -> Q = 1,0,0,0,0,0,0,0.
